// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-beverage vending controller with credit, change and timed delivery lockout
module vending_machine_multi #(
  parameter int NUM_BEV     = 2,
  parameter int CREDIT_W    = 8,
  parameter int BASE_PRICE  = 30,
  parameter int PRICE_STEP  = 20,
  parameter int MAX_CREDIT  = 250,
  parameter int DELIVER_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          coin_in,
  input  logic [2:0]          button_in,
  input  logic                cancel_in,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          beverage_out,
  output logic [CREDIT_W-1:0] change_out,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                busy
);

  localparam int TOP_PRICE = BASE_PRICE + (NUM_BEV - 1) * PRICE_STEP;
  localparam int SUM_W     = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
  localparam int CNT_W     = (DELIVER_CYC > 1) ? $clog2(DELIVER_CYC) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DELIVER_CYC - 1);
  localparam logic [SUM_W-1:0]    MAX_SUM  = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] BASE_C   = CREDIT_W'(BASE_PRICE);

  generate
    if (NUM_BEV < 1 || NUM_BEV > 7 || DELIVER_CYC < 1 ||
        MAX_CREDIT > (2 ** CREDIT_W) - 1 || MAX_CREDIT < TOP_PRICE) begin : g_bad_params
      $error("vending_machine_multi: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_DELIVER, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [2:0]          beverage_q, beverage_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                coin_valid;
  logic                coin_fits;
  logic [SUM_W-1:0]    coin_sum;
  logic                btn_valid;
  logic [CREDIT_W-1:0] btn_price;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [2:0] k);
    return CREDIT_W'(BASE_PRICE + (int'(k) - 1) * PRICE_STEP);
  endfunction

  always_comb begin
    coin_valid = 1'b0;
    case (coin_in)
      8'd10, 8'd20, 8'd50, 8'd100, 8'd200: coin_valid = 1'b1;
      default:                             coin_valid = 1'b0;
    endcase
    // Widened sum so an over-ceiling coin can never wrap into a small credit.
    coin_sum  = SUM_W'(credit_q) + SUM_W'(coin_in);
    coin_fits = coin_valid && (coin_sum <= MAX_SUM);
    btn_valid = (button_in != '0) && (button_in <= 3'(NUM_BEV));
    btn_price = price_of(button_in);
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    beverage_d     = beverage_q;
    change_d       = '0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    cnt_d          = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cancel_in) begin
          coin_reject_d = (coin_in != '0);
          if (credit_q != '0) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = S_CHANGE;
          end
        end else if (btn_valid && (credit_q >= btn_price)) begin
          credit_d      = credit_q - btn_price;
          beverage_d    = button_in;
          cnt_d         = CNT_LAST;
          state_d       = S_DELIVER;
          coin_reject_d = (coin_in != '0);
        end else begin
          insufficient_d = btn_valid;
          if (coin_in != '0) begin
            if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
            else           coin_reject_d = 1'b1;
          end
        end
      end
      S_DELIVER: begin
        coin_reject_d = (coin_in != '0);
        if (cnt_q == '0) begin
          beverage_d = '0;
          // Leftover credit too small to buy anything is paid out automatically.
          if ((credit_q != '0) && (credit_q < BASE_C)) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = S_CHANGE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHANGE: begin
        coin_reject_d = (coin_in != '0);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      beverage_q     <= '0;
      change_q       <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      beverage_q     <= beverage_d;
      change_q       <= change_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
    end
  end

  assign credit       = credit_q;
  assign beverage_out = beverage_q;
  assign change_out   = change_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb/tb_vending_machine_multi.sv - directed self-checking bench for vending_machine_multi (default parameters)
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] coin_in = '0;
  logic [2:0] button_in = '0;
  logic       cancel_in = 1'b0;
  logic [7:0] credit;
  logic [2:0] beverage_out;
  logic [7:0] change_out;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  int errors = 0;
  int checks = 0;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .button_in(button_in), .cancel_in(cancel_in),
    .credit(credit), .beverage_out(beverage_out), .change_out(change_out),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  // Present inputs for one rising edge, then sample 1 time unit after it.
  task automatic cyc(input logic [7:0] c, input logic [2:0] b, input logic x);
    coin_in = c; button_in = b; cancel_in = x;
    @(posedge clk); #1;
    coin_in = '0; button_in = '0; cancel_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(8'd50, 3'd1, 1'b0);
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    checks++; if (beverage_out !== 3'd0) begin errors++; $display("FAIL reset_bev got=%0d exp=0", beverage_out); end
    checks++; if (change_out !== 8'd0) begin errors++; $display("FAIL reset_change got=%0d exp=0", change_out); end
    checks++; if ({coin_reject, insufficient, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {coin_reject, insufficient, busy}); end
    rst = 1'b0;
  endtask

  task automatic test_buy_exact;
    cyc(8'd20, 3'd0, 1'b0);
    checks++; if (credit !== 8'd20) begin errors++; $display("FAIL t1_credit20 got=%0d exp=20", credit); end
    cyc(8'd10, 3'd0, 1'b0);
    checks++; if (credit !== 8'd30) begin errors++; $display("FAIL t1_credit30 got=%0d exp=30", credit); end
    cyc(8'd0, 3'd1, 1'b0);
    checks++; if (beverage_out !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL t1_start got bev=%0d busy=%b exp bev=1 busy=1", beverage_out, busy); end
    checks++; if (credit !== 8'd0 || change_out !== 8'd0) begin errors++; $display("FAIL t1_credit_after got credit=%0d change=%0d exp 0 0", credit, change_out); end
    for (int i = 0; i < 2; i++) begin
      cyc(8'd0, 3'd0, 1'b0);
      checks++; if (beverage_out !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL t1_hold%0d got bev=%0d busy=%b exp bev=1 busy=1", i, beverage_out, busy); end
    end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (beverage_out !== 3'd0 || busy !== 1'b0 || change_out !== 8'd0) begin errors++; $display("FAIL t1_end got bev=%0d busy=%b change=%0d exp 0 0 0", beverage_out, busy, change_out); end
  endtask

  task automatic test_retain_credit;
    cyc(8'd100, 3'd0, 1'b0);
    checks++; if (credit !== 8'd100) begin errors++; $display("FAIL t2_credit100 got=%0d exp=100", credit); end
    cyc(8'd10, 3'd2, 1'b0);
    checks++; if (beverage_out !== 3'd2 || credit !== 8'd50 || coin_reject !== 1'b1) begin errors++; $display("FAIL t2_buy got bev=%0d credit=%0d rej=%b exp 2 50 1", beverage_out, credit, coin_reject); end
    cyc(8'd0, 3'd0, 1'b0);
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (beverage_out !== 3'd2) begin errors++; $display("FAIL t2_hold got=%0d exp=2", beverage_out); end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (beverage_out !== 3'd0 || busy !== 1'b0 || credit !== 8'd50 || change_out !== 8'd0) begin errors++; $display("FAIL t2_end got bev=%0d busy=%b credit=%0d change=%0d exp 0 0 50 0", beverage_out, busy, credit, change_out); end
    cyc(8'd0, 3'd0, 1'b1);
    checks++; if (change_out !== 8'd50 || credit !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL t2_cancel got change=%0d credit=%0d busy=%b exp 50 0 1", change_out, credit, busy); end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (change_out !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL t2_cancel_end got change=%0d busy=%b exp 0 0", change_out, busy); end
  endtask

  task automatic test_change_after_delivery;
    cyc(8'd50, 3'd0, 1'b0);
    cyc(8'd10, 3'd0, 1'b0);
    checks++; if (credit !== 8'd60) begin errors++; $display("FAIL t3_credit60 got=%0d exp=60", credit); end
    cyc(8'd0, 3'd2, 1'b0);
    checks++; if (credit !== 8'd10 || beverage_out !== 3'd2) begin errors++; $display("FAIL t3_buy got credit=%0d bev=%0d exp 10 2", credit, beverage_out); end
    cyc(8'd0, 3'd1, 1'b1);
    checks++; if (beverage_out !== 3'd2 || credit !== 8'd10 || change_out !== 8'd0) begin errors++; $display("FAIL t3_ignore got bev=%0d credit=%0d change=%0d exp 2 10 0", beverage_out, credit, change_out); end
    cyc(8'd0, 3'd0, 1'b0);
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (change_out !== 8'd10 || credit !== 8'd0 || beverage_out !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL t3_change got change=%0d credit=%0d bev=%0d busy=%b exp 10 0 0 1", change_out, credit, beverage_out, busy); end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (change_out !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL t3_change_end got change=%0d busy=%b exp 0 0", change_out, busy); end
  endtask

  task automatic test_coin_reject;
    cyc(8'd25, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin errors++; $display("FAIL t4_rej25 got rej=%b credit=%0d exp 1 0", coin_reject, credit); end
    cyc(8'd7, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin errors++; $display("FAIL t4_rej7 got rej=%b credit=%0d exp 1 0", coin_reject, credit); end
    cyc(8'd200, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd200) begin errors++; $display("FAIL t4_acc200 got rej=%b credit=%0d exp 0 200", coin_reject, credit); end
    cyc(8'd100, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL t4_over got rej=%b credit=%0d exp 1 200", coin_reject, credit); end
    cyc(8'd50, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b0 || credit !== 8'd250) begin errors++; $display("FAIL t4_at_max got rej=%b credit=%0d exp 0 250", coin_reject, credit); end
    cyc(8'd10, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd250) begin errors++; $display("FAIL t4_above_max got rej=%b credit=%0d exp 1 250", coin_reject, credit); end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL t4_rej_pulse got=%b exp=0", coin_reject); end
    cyc(8'd0, 3'd0, 1'b1);
    checks++; if (change_out !== 8'd250 || credit !== 8'd0) begin errors++; $display("FAIL t4_refund got change=%0d credit=%0d exp 250 0", change_out, credit); end
    cyc(8'd0, 3'd0, 1'b0);
  endtask

  task automatic test_insufficient_cancel;
    cyc(8'd20, 3'd0, 1'b0);
    cyc(8'd0, 3'd1, 1'b0);
    checks++; if (insufficient !== 1'b1 || credit !== 8'd20 || beverage_out !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_insuf got ins=%b credit=%0d bev=%0d busy=%b exp 1 20 0 0", insufficient, credit, beverage_out, busy); end
    cyc(8'd10, 3'd2, 1'b0);
    checks++; if (insufficient !== 1'b1 || credit !== 8'd30 || coin_reject !== 1'b0) begin errors++; $display("FAIL t5_insuf_coin got ins=%b credit=%0d rej=%b exp 1 30 0", insufficient, credit, coin_reject); end
    cyc(8'd0, 3'd7, 1'b0);
    checks++; if (insufficient !== 1'b0 || beverage_out !== 3'd0 || credit !== 8'd30) begin errors++; $display("FAIL t5_bad_button got ins=%b bev=%0d credit=%0d exp 0 0 30", insufficient, beverage_out, credit); end
    cyc(8'd10, 3'd1, 1'b1);
    checks++; if (change_out !== 8'd30 || credit !== 8'd0 || coin_reject !== 1'b1 || beverage_out !== 3'd0) begin errors++; $display("FAIL t5_cancel got change=%0d credit=%0d rej=%b bev=%0d exp 30 0 1 0", change_out, credit, coin_reject, beverage_out); end
    cyc(8'd0, 3'd0, 1'b0);
    checks++; if (change_out !== 8'd0 || credit !== 8'd0) begin errors++; $display("FAIL t5_cancel_end got change=%0d credit=%0d exp 0 0", change_out, credit); end
    cyc(8'd10, 3'd0, 1'b1);
    checks++; if (coin_reject !== 1'b1 || change_out !== 8'd0 || busy !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL t5_cancel_empty got rej=%b change=%0d busy=%b credit=%0d exp 1 0 0 0", coin_reject, change_out, busy, credit); end
  endtask

  task automatic test_reset_mid_delivery;
    cyc(8'd50, 3'd0, 1'b0);
    cyc(8'd0, 3'd1, 1'b0);
    checks++; if (beverage_out !== 3'd1 || credit !== 8'd20) begin errors++; $display("FAIL t6_buy got bev=%0d credit=%0d exp 1 20", beverage_out, credit); end
    cyc(8'd10, 3'd0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd20 || beverage_out !== 3'd1) begin errors++; $display("FAIL t6_coin_locked got rej=%b credit=%0d bev=%0d exp 1 20 1", coin_reject, credit, beverage_out); end
    rst = 1'b1;
    cyc(8'd0, 3'd0, 1'b0);
    rst = 1'b0;
    checks++; if (credit !== 8'd0 || beverage_out !== 3'd0 || change_out !== 8'd0 || {coin_reject, insufficient, busy} !== 3'b000) begin errors++; $display("FAIL t6_reset got credit=%0d bev=%0d change=%0d flags=%b exp all 0", credit, beverage_out, change_out, {coin_reject, insufficient, busy}); end
    for (int i = 0; i < 3; i++) begin
      cyc(8'd0, 3'd0, 1'b0);
      checks++; if (change_out !== 8'd0 || busy !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL t6_quiet%0d got change=%0d busy=%b credit=%0d exp 0 0 0", i, change_out, busy, credit); end
    end
  endtask

  initial begin
    test_reset();
    test_buy_exact();
    test_retain_credit();
    test_change_after_delivery();
    test_coin_reject();
    test_insufficient_cancel();
    test_reset_mid_delivery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
